// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM state encoding and the saturation digit.
package bin2bcd_seq_pkg;

   localparam int BCD_DIGIT_W = 4;

   localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
   import bin2bcd_seq_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] fixed
);

   always_comb begin
      fixed = digit;
      if (digit >= 4'd5) begin
         fixed = digit + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock,
// with overflow saturation and a leading-zero blank mask for the display.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic [DIGITS-1:0]             blank,
   output logic                          overflow
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [BIN_W-1:0]    bin_sr;
   logic [BCD_W-1:0]    work;
   logic                ovf_sticky;

   logic [BCD_W-1:0]       corr;
   logic [BCD_W+BIN_W-1:0] shifted;
   logic                   ovf_next;
   logic [BCD_W-1:0]       fin_bcd;

   function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] value,
                                                 input logic           ovf);
      return ovf ? {DIGITS{BCD_NINE}} : value;
   endfunction

   // Digit 0 is never blanked so a zero result still shows one "0".
   function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] value);
      logic [DIGITS-1:0] m;
      logic              zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (value[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         m[i]       = zero_above;
      end
      return m;
   endfunction

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .fixed (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // A 1 leaving the top digit means the value needs more digits than we have.
   assign shifted  = {corr, bin_sr} << 1;
   assign ovf_next = ovf_sticky | corr[BCD_W-1];
   assign fin_bcd  = saturate(shifted[BCD_W+BIN_W-1 -: BCD_W], ovf_next);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         bcd        <= '0;
         blank      <= BLANK_RST;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  bin_sr     <= bin;
                  work       <= '0;
                  cnt        <= CNT_W'(BIN_W);
                  ovf_sticky <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               {work, bin_sr} <= shifted;
               ovf_sticky     <= ovf_next;
               cnt            <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bcd      <= fin_bcd;
                  blank    <= blank_mask(fin_bcd);
                  overflow <= ovf_next;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector tables, multi-cycle corner
// sequences and random values against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, busy, done, overflow;
   logic [15:0] bin;
   logic [19:0] bcd;
   logic [4:0]  blank;

   logic        start8, busy8, done8, overflow8;
   logic [7:0]  bin8, bcd8;
   logic [1:0]  blank8;

   int checks = 0;
   int errors = 0;

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
      .bcd(bcd), .blank(blank), .overflow(overflow)
   );

   bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .bin(bin8), .busy(busy8), .done(done8),
      .bcd(bcd8), .blank(blank8), .overflow(overflow8)
   );

   typedef struct packed {
      logic [31:0] bcd;
      logic [7:0]  blank;
      logic        ovf;
   } res_t;

   typedef struct packed {
      logic [15:0] bin;
      logic [19:0] bcd;
      logic [4:0]  blank;
      logic        ovf;
   } vec16_t;

   typedef struct packed {
      logic [7:0] bin;
      logic [7:0] bcd;
      logic [1:0] blank;
      logic       ovf;
   } vec8_t;

   // Decimal reference: digits via /10 and %10, blank[i] iff shown value < 10**i.
   function automatic res_t model(input int unsigned v, input int digits);
      res_t        r;
      int unsigned lim, shown, p;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      r.ovf   = (v >= lim);
      shown   = r.ovf ? lim - 1 : v;
      r.bcd   = '0;
      p       = shown;
      for (int i = 0; i < digits; i++) begin
         r.bcd[i*4 +: 4] = 4'(p % 10);
         p = p / 10;
      end
      r.blank = '0;
      p       = 1;
      for (int i = 0; i < digits; i++) begin
         if (i > 0) r.blank[i] = (shown < p);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge where done is seen.
   task automatic conv16(input logic [15:0] v, output logic ok, output int lat, output int busy_n);
      ok     = 1'b0;
      lat    = -1;
      busy_n = 0;
      start  = 1'b1;
      bin    = v;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            bin   = 16'($urandom);
         end
         if (busy) busy_n++;
         if (done) begin
            ok  = 1'b1;
            lat = k;
            break;
         end
      end
   endtask

   task automatic conv8(input logic [7:0] v, output logic ok);
      ok     = 1'b0;
      start8 = 1'b1;
      bin8   = v;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start8 = 1'b0;
            bin8   = 8'($urandom);
         end
         if (done8) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   vec16_t vecs[10];
   vec8_t  vecs8[6];

   initial begin
      logic        ok;
      int          lat, bn, c1, c2, ndone;
      res_t        r;
      logic [15:0] rv;
      logic [7:0]  rv8;

      vecs[0] = '{16'd0,     20'h00000, 5'b11110, 1'b0};
      vecs[1] = '{16'd65535, 20'h65535, 5'b00000, 1'b0};
      vecs[2] = '{16'd1234,  20'h01234, 5'b10000, 1'b0};
      vecs[3] = '{16'd42,    20'h00042, 5'b11100, 1'b0};
      vecs[4] = '{16'd7,     20'h00007, 5'b11110, 1'b0};
      vecs[5] = '{16'd500,   20'h00500, 5'b11000, 1'b0};
      vecs[6] = '{16'd9,     20'h00009, 5'b11110, 1'b0};
      vecs[7] = '{16'd10,    20'h00010, 5'b11100, 1'b0};
      vecs[8] = '{16'd10000, 20'h10000, 5'b00000, 1'b0};
      vecs[9] = '{16'd9999,  20'h09999, 5'b10000, 1'b0};

      vecs8[0] = '{8'd99,  8'h99, 2'b00, 1'b0};
      vecs8[1] = '{8'd100, 8'h99, 2'b00, 1'b1};
      vecs8[2] = '{8'd255, 8'h99, 2'b00, 1'b1};
      vecs8[3] = '{8'd0,   8'h00, 2'b10, 1'b0};
      vecs8[4] = '{8'd9,   8'h09, 2'b10, 1'b0};
      vecs8[5] = '{8'd10,  8'h10, 2'b00, 1'b0};

      rst = 1'b1; start = 1'b0; bin = '0; start8 = 1'b0; bin8 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bcd", bcd, 0);
      check("rst_blank", blank, 5'b11110);
      check("rst_ovf", overflow, 0);
      check("rst_blank8", blank8, 2'b10);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         conv16(vecs[i].bin, ok, lat, bn);
         check($sformatf("vec%0d_done", i), ok, 1);
         check($sformatf("vec%0d_latency", i), lat, 16);
         check($sformatf("vec%0d_busy_cycles", i), bn, 16);
         check($sformatf("vec%0d_bcd", i), bcd, vecs[i].bcd);
         check($sformatf("vec%0d_blank", i), blank, vecs[i].blank);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
         @(negedge clk);
         check($sformatf("vec%0d_done_one_cycle", i), done, 0);
      end

      // Second start during a conversion is dropped; outputs hold while shifting.
      start = 1'b1; bin = 16'd1234; ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 4) begin start = 1'b1; bin = 16'd9999; end
         if (k == 5) start = 1'b0;
         if (k == 8) check("hold_bcd_during_shift", bcd, vecs[9].bcd);
         if (done) begin ok = 1'b1; break; end
      end
      check("ign_done", ok, 1);
      check("ign_bcd", bcd, 20'h01234);
      check("ign_blank", blank, 5'b10000);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("ign_no_second_done", ndone, 0);
      check("ign_idle_busy", busy, 0);

      // Back-to-back: start held high, next operand presented on the done cycle.
      start = 1'b1; bin = 16'd42; c1 = -1; c2 = -1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (done && c1 < 0) begin
            c1 = k;
            check("b2b_first_bcd", bcd, 20'h00042);
            check("b2b_first_blank", blank, 5'b11100);
            bin = 16'd7;
         end else if (c1 >= 0 && k == c1 + 1) begin
            start = 1'b0;
         end else if (done && c1 >= 0) begin
            c2 = k;
            break;
         end
      end
      start = 1'b0;
      check("b2b_second_done", (c2 >= 0), 1);
      check("b2b_spacing", c2 - c1, 17);
      check("b2b_second_bcd", bcd, 20'h00007);
      check("b2b_second_blank", blank, 5'b11110);

      // Reset in the middle of a conversion.
      @(negedge clk);
      start = 1'b1; bin = 16'd500;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 7) rst = 1'b1;
      end
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_bcd", bcd, 0);
      check("mid_rst_blank", blank, 5'b11110);
      rst = 1'b0;
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mid_rst_no_done", ndone, 0);
      conv16(16'd500, ok, lat, bn);
      check("post_rst_done", ok, 1);
      check("post_rst_latency", lat, 16);
      check("post_rst_bcd", bcd, 20'h00500);
      check("post_rst_blank", blank, 5'b11000);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rv = 16'($urandom_range(0, 65535));
         r  = model(32'(rv), 5);
         conv16(rv, ok, lat, bn);
         check($sformatf("rnd16_%0d_done", rv), ok, 1);
         check($sformatf("rnd16_%0d_bcd", rv), bcd, r.bcd[19:0]);
         check($sformatf("rnd16_%0d_blank", rv), blank, r.blank[4:0]);
         check($sformatf("rnd16_%0d_ovf", rv), overflow, r.ovf);
      end

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         conv8(vecs8[i].bin, ok);
         check($sformatf("v8_%0d_done", i), ok, 1);
         check($sformatf("v8_%0d_bcd", i), bcd8, vecs8[i].bcd);
         check($sformatf("v8_%0d_blank", i), blank8, vecs8[i].blank);
         check($sformatf("v8_%0d_ovf", i), overflow8, vecs8[i].ovf);
      end

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rv8 = 8'($urandom_range(0, 255));
         r   = model(32'(rv8), 2);
         conv8(rv8, ok);
         check($sformatf("rnd8_%0d_done", rv8), ok, 1);
         check($sformatf("rnd8_%0d_bcd", rv8), bcd8, r.bcd[7:0]);
         check($sformatf("rnd8_%0d_blank", rv8), blank8, r.blank[1:0]);
         check($sformatf("rnd8_%0d_ovf", rv8), overflow8, r.ovf);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
